// File: rtl/logic_unit_pkg.sv
// Shared opcodes and sizing helpers for the pipelined EX-stage logic unit.
package logic_unit_pkg;

  localparam int OPSEL_W = 4;

  localparam logic [OPSEL_W-1:0] LU_AND  = 4'b0000;
  localparam logic [OPSEL_W-1:0] LU_OR   = 4'b0001;
  localparam logic [OPSEL_W-1:0] LU_NOR  = 4'b0010;
  localparam logic [OPSEL_W-1:0] LU_XOR  = 4'b0011;
  localparam logic [OPSEL_W-1:0] LU_SLT  = 4'b0100;
  localparam logic [OPSEL_W-1:0] LU_SLTU = 4'b0101;
  localparam logic [OPSEL_W-1:0] LU_SLL  = 4'b0110;
  localparam logic [OPSEL_W-1:0] LU_SRL  = 4'b0111;
  localparam logic [OPSEL_W-1:0] LU_SRA  = 4'b1000;
  localparam logic [OPSEL_W-1:0] LU_LUI  = 4'b1001;

  // Shift-amount width for a given datapath width.
  function automatic int shw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle between the ID/EX latch, the logic unit and EX/MEM.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  import logic_unit_pkg::*;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [OPSEL_W-1:0] opsel;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               illegal;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, op_a, op_b, opsel, in_tag, out_ready,
    input  in_ready, out_valid, result, zero, illegal, out_tag
  );

  modport slave (
    input  flush, in_valid, op_a, op_b, opsel, in_tag, out_ready,
    output in_ready, out_valid, result, zero, illegal, out_tag
  );

endinterface

// File: rtl/logic_unit_core.sv
// Purely combinational evaluation of one logic/compare/shift op.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [OPSEL_W-1:0] i_opsel,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_illegal
);

  localparam int SHW = shw(WIDTH);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  // Opcode decode; unassigned encodings yield zero and flag illegal.
  always_comb begin
    o_result  = {WIDTH{1'b0}};
    o_illegal = 1'b0;
    case (i_opsel)
      LU_AND:  o_result = i_a & i_b;
      LU_OR:   o_result = i_a | i_b;
      LU_NOR:  o_result = ~(i_a | i_b);
      LU_XOR:  o_result = i_a ^ i_b;
      LU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      LU_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      LU_SLL:  o_result = i_a << w_shamt;
      LU_SRL:  o_result = i_a >> w_shamt;
      LU_SRA:  o_result = $signed(i_a) >>> w_shamt;
      LU_LUI:  o_result = {i_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: begin
        o_result  = {WIDTH{1'b0}};
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_unit_core: S1 latches operands, S2 latches results.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave lu
);

  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic [OPSEL_W-1:0] r_s1_opsel;
  logic [TAG_W-1:0]   r_s1_tag;

  logic               r_s2_valid;
  logic [WIDTH-1:0]   r_s2_result;
  logic               r_s2_zero;
  logic               r_s2_illegal;
  logic [TAG_W-1:0]   r_s2_tag;

  logic               w_s1_load;
  logic               w_s2_load;
  logic               w_in_ready;
  logic [WIDTH-1:0]   w_core_result;
  logic               w_core_illegal;

  // S2 may refill in the same cycle it drains, so in_ready looks through out_ready.
  assign w_s2_load  = r_s1_valid && (!r_s2_valid || lu.out_ready);
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_s1_load  = lu.in_valid && w_in_ready;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .i_a       (r_s1_a),
    .i_b       (r_s1_b),
    .i_opsel   (r_s1_opsel),
    .o_result  (w_core_result),
    .o_illegal (w_core_illegal)
  );

  // Stage valid bits; flush outranks every load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (lu.flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_load)      r_s1_valid <= 1'b1;
      else if (w_s2_load) r_s1_valid <= 1'b0;
      else                r_s1_valid <= r_s1_valid;

      if (w_s2_load)         r_s2_valid <= 1'b1;
      else if (lu.out_ready) r_s2_valid <= 1'b0;
      else                   r_s2_valid <= r_s2_valid;
    end
  end

  // S1 operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_a     <= {WIDTH{1'b0}};
      r_s1_b     <= {WIDTH{1'b0}};
      r_s1_opsel <= {OPSEL_W{1'b0}};
      r_s1_tag   <= {TAG_W{1'b0}};
    end else if (!lu.flush && w_s1_load) begin
      r_s1_a     <= lu.op_a;
      r_s1_b     <= lu.op_b;
      r_s1_opsel <= lu.opsel;
      r_s1_tag   <= lu.in_tag;
    end
  end

  // S2 result capture; outputs hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_result  <= {WIDTH{1'b0}};
      r_s2_zero    <= 1'b0;
      r_s2_illegal <= 1'b0;
      r_s2_tag     <= {TAG_W{1'b0}};
    end else if (!lu.flush && w_s2_load) begin
      r_s2_result  <= w_core_result;
      r_s2_zero    <= (w_core_result == {WIDTH{1'b0}});
      r_s2_illegal <= w_core_illegal;
      r_s2_tag     <= r_s1_tag;
    end
  end

  assign lu.in_ready  = w_in_ready;
  assign lu.out_valid = r_s2_valid;
  assign lu.result    = r_s2_result;
  assign lu.zero      = r_s2_zero;
  assign lu.illegal   = r_s2_illegal;
  assign lu.out_tag   = r_s2_tag;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe at WIDTH=32 and WIDTH=16.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic_unit_pipe_if #(.WIDTH(32), .TAG_W(5)) lu32 ();
  logic_unit_pipe_if #(.WIDTH(16), .TAG_W(5)) lu16 ();

  logic_unit_pipe #(.WIDTH(32), .TAG_W(5)) u_dut32 (.clk(clk), .rst(rst), .lu(lu32));
  logic_unit_pipe #(.WIDTH(16), .TAG_W(5)) u_dut16 (.clk(clk), .rst(rst), .lu(lu16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
    lu32.opsel  = sel;
    lu32.op_a   = a;
    lu32.op_b   = b;
    lu32.in_tag = tag;
  endtask

  // Issue one op into an empty pipe and check it appears exactly two edges later.
  task automatic run_op(input string name, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] er,
                        input logic ez, input logic ei);
    drive32(sel, a, b, tag);
    lu32.out_ready = 1'b1;
    lu32.in_valid  = 1'b1;
    cyc();
    lu32.in_valid = 1'b0;
    chk({name, "_early"}, {31'd0, lu32.out_valid}, 32'd0);
    cyc();
    chk({name, "_valid"}, {31'd0, lu32.out_valid}, 32'd1);
    chk({name, "_res"}, lu32.result, er);
    chk({name, "_zero"}, {31'd0, lu32.zero}, {31'd0, ez});
    chk({name, "_ill"}, {31'd0, lu32.illegal}, {31'd0, ei});
    chk({name, "_tag"}, {27'd0, lu32.out_tag}, {27'd0, tag});
  endtask

  task automatic run16(input string name, input logic [3:0] sel, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er);
    lu16.opsel    = sel;
    lu16.op_a     = a;
    lu16.op_b     = b;
    lu16.in_tag   = 5'd9;
    lu16.in_valid = 1'b1;
    cyc();
    lu16.in_valid = 1'b0;
    cyc();
    chk({name, "_valid"}, {31'd0, lu16.out_valid}, 32'd1);
    chk({name, "_res"}, {16'd0, lu16.result}, {16'd0, er});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    int c;
    logic saw_stall;
    logic [31:0] held;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    lu32.flush = 1'b0; lu32.in_valid = 1'b0; lu32.out_ready = 1'b1;
    drive32(4'd0, 32'd0, 32'd0, 5'd0);
    lu16.flush = 1'b0; lu16.in_valid = 1'b0; lu16.out_ready = 1'b1;
    lu16.opsel = 4'd0; lu16.op_a = 16'd0; lu16.op_b = 16'd0; lu16.in_tag = 5'd0;
    cyc();
    cyc();
    chk("rst_in_ready", {31'd0, lu32.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, lu32.out_valid}, 32'd0);
    chk("rst_result", lu32.result, 32'd0);
    chk("rst_flags", {30'd0, lu32.zero, lu32.illegal}, 32'd0);
    chk("rst_tag", {27'd0, lu32.out_tag}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_in_ready", {31'd0, lu32.in_ready}, 32'd1);

    // Basic ops, compares, shifts, LUI, illegal.
    run_op("and",  LU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd1, 32'h00F0_000F, 1'b0, 1'b0);
    run_op("or",   LU_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd2, 32'hFFF0_0FFF, 1'b0, 1'b0);
    run_op("nor",  LU_NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd3, 32'h000F_F000, 1'b0, 1'b0);
    run_op("xor",  LU_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd4, 32'hFF00_0FF0, 1'b0, 1'b0);
    run_op("slt",  LU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd5, 32'h0000_0001, 1'b0, 1'b0);
    run_op("sltu", LU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sll",  LU_SLL,  32'h8000_0010, 32'h0000_0004, 5'd7, 32'h0000_0100, 1'b0, 1'b0);
    run_op("srl",  LU_SRL,  32'h8000_0010, 32'h0000_0024, 5'd8, 32'h0800_0001, 1'b0, 1'b0);
    run_op("sra",  LU_SRA,  32'h8000_0010, 32'h0000_0004, 5'd9, 32'hF800_0001, 1'b0, 1'b0);
    run_op("lui",  LU_LUI,  32'h8000_0010, 32'h0000_1234, 5'd10, 32'h1234_0000, 1'b0, 1'b0);
    run_op("ill",  4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1'b1, 1'b1);
    cyc();

    // Backpressure: four tagged ops, consumer stalls for three cycles mid-stream.
    sent = 0; got = 0; c = 0; saw_stall = 1'b0; held = 32'd0;
    while (got < 4 && c < 30) begin
      lu32.out_ready = !(c >= 2 && c <= 4);
      lu32.in_valid  = (sent < 4);
      drive32(LU_AND, (sent + 1) * 32'h0101_0101, 32'hFFFF_FFFF, 5'(sent + 1));
      #1;
      if (c == 2) held = lu32.result;
      if (c == 4) chk("bp_hold", lu32.result, held);
      if (!lu32.in_ready) saw_stall = 1'b1;
      if (lu32.out_valid && lu32.out_ready) begin
        chk("bp_tag", {27'd0, lu32.out_tag}, got + 1);
        chk("bp_res", lu32.result, (got + 1) * 32'h0101_0101);
        got++;
      end
      if (lu32.in_valid && lu32.in_ready) sent++;
      c++;
      cyc();
    end
    lu32.in_valid = 1'b0;
    lu32.out_ready = 1'b1;
    chk("bp_count", got, 32'd4);
    chk("bp_stall_seen", {31'd0, saw_stall}, 32'd1);
    cyc();

    // Flush with both stages full and a third op offered.
    lu32.out_ready = 1'b0;
    drive32(LU_OR, 32'h1, 32'h2, 5'd20);
    lu32.in_valid = 1'b1;
    cyc();
    drive32(LU_OR, 32'h3, 32'h4, 5'd21);
    cyc();
    chk("fl_full_in_ready", {31'd0, lu32.in_ready}, 32'd0);
    drive32(LU_OR, 32'h5, 32'h6, 5'd22);
    lu32.flush = 1'b1;
    cyc();
    lu32.flush = 1'b0;
    chk("fl_out_valid", {31'd0, lu32.out_valid}, 32'd0);
    lu32.out_ready = 1'b1;
    drive32(LU_AND, 32'h0000_FFFF, 32'h00FF_00FF, 5'd7);
    cyc();
    lu32.in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 5; i++) begin
      if (lu32.out_valid) begin
        chk("fl_after_tag", {27'd0, lu32.out_tag}, 32'd7);
        chk("fl_after_res", lu32.result, 32'h0000_00FF);
        got++;
      end
      cyc();
    end
    chk("fl_after_count", got, 32'd1);

    // Asynchronous reset between edges with ops in flight.
    lu32.out_ready = 1'b0;
    drive32(LU_XOR, 32'hFF00_FF00, 32'h0, 5'd3);
    lu32.in_valid = 1'b1;
    cyc();
    drive32(LU_XOR, 32'h00FF_00FF, 32'h0, 5'd4);
    cyc();
    lu32.in_valid = 1'b0;
    chk("ar_pre_valid", {31'd0, lu32.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, lu32.out_valid}, 32'd0);
    chk("ar_result", lu32.result, 32'd0);
    chk("ar_tag", {27'd0, lu32.out_tag}, 32'd0);
    chk("ar_in_ready", {31'd0, lu32.in_ready}, 32'd1);
    #1;
    rst = 1'b0;
    cyc();
    run_op("ar_after", LU_SRL, 32'hF000_0000, 32'h0000_0008, 5'd12, 32'h00F0_0000, 1'b0, 1'b0);
    cyc();

    // Narrow instance.
    run16("w16_sra", LU_SRA, 16'h8001, 16'h000F, 16'hFFFF);
    run16("w16_lui", LU_LUI, 16'h5555, 16'h00AB, 16'hAB00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
